execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the pipelined RV32I core. Consumes the ID/EX bundle registered by the decode stage, computes the ALU result, resolves branches and jumps, and registers the EX/MEM bundle for the memory stage. On a taken branch or jump it issues a PC redirect to fetch and squashes the two wrong-path bundles that follow, because the decode stage has no flush input.

## Interface
- No parameters.
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ID_EX_PC, ID_EX_A, ID_EX_B, ID_EX_IMM  in  32 each  PC, rs1 data, rs2 data, sign-extended immediate
- ID_EX_RD  in  5  destination register
- alu_type_sel  in  2  00 ALU op, 01 A+IMM (load/store/JALR), 10 pass IMM (LUI), 11 PC+IMM (AUIPC)
- alucontrol  in  3  funct3
- alucontrol7  in  7  funct7
- b_imm_sel  in  1  1: ALU operand B = IMM; 0: operand B = B
- branch, jump, memwrite_en, regwrite_en, wb_sel  in  1 each  control bits from decode
- EX_MEM_ALU  out  32  ALU result, or PC+4 for jumps
- EX_MEM_WD  out  32  store data (operand B after forwarding)
- EX_MEM_RD  out  5  destination register
- EX_MEM_F3  out  3  funct3, used for memory access width
- EX_MEM_memwrite_en, EX_MEM_regwrite_en, EX_MEM_wb_sel  out  1 each  registered control bits
- pc_redirect  out  1  combinational; 1 = fetch loads pc_target at the next edge
- pc_target  out  32  combinational redirect address

## Operation
- ALU op, used when alu_type_sel=00. Operand B is IMM when b_imm_sel=1, otherwise B.
  - 000: add, or sub when alucontrol7[5]=1 and b_imm_sel=0.
  - 001: sll. 010: slt (signed). 011: sltu.
  - 100: xor. 101: srl, or sra when alucontrol7[5]=1. 110: or. 111: and.
  - Shift amount is opB[4:0]. All arithmetic is 32-bit modulo 2^32.
- Branch, when branch=1. Comparison is on A vs B and selected by funct3:
  - 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
  - 010 and 011 are never taken.
  - Target is PC+IMM.
- Jump, when jump=1. Always taken.
  - When alu_type_sel=01 the jump is JALR: target = (A+IMM) & ~1.
  - Otherwise it is JAL: target = PC+IMM.
  - EX_MEM_ALU = PC+4.
- pc_redirect = (taken branch or jump) and not squashed.
- pc_target is don't-care when pc_redirect=0; the implementation drives 0.
- Squash counter `sq` is 2 bits:
  - A taken redirect loads sq=2 at the next edge.
  - Otherwise sq decrements while it is nonzero.
  - While sq≠0, the current bundle is squashed: EX_MEM_regwrite_en and EX_MEM_memwrite_en are registered as 0, and pc_redirect is forced to 0.
  - Data fields are still registered as computed.
- A redirect from a non-squashed bundle always reloads sq to 2. A squashed bundle cannot cause a redirect.
- Misaligned targets are not checked.

## Timing
- Latency is 1 cycle from the ID/EX inputs to the EX/MEM outputs.
- pc_redirect and pc_target are combinational in the same cycle and are sampled by fetch at the next edge.
- Reset (asynchronous): every EX_MEM_* output = 0 and sq = 0.
- After reset, pc_redirect = 0, because all ID/EX inputs are 0, which is a bubble.
- Reset asserted mid-squash clears sq immediately. The first bundle after release is not squashed.
- After a taken redirect in cycle N:
  - Bundles present in cycles N+1 and N+2 are squashed.
  - The bundle at N+3 is the target instruction and executes normally.
- A write to x0 is not prevented here; the register file ignores it.

## Configuration
- Macro: `EX_FWD_EN`.
- Defined:
  - Adds inputs ID_EX_RS1[4:0], ID_EX_RS2[4:0], MEM_WB_regwrite, MEM_WB_RD[4:0] and MEM_WB_WD[31:0].
  - Each of operands A and B is forwarded from EX/MEM when EX_MEM_regwrite_en=1, EX_MEM_wb_sel=0, EX_MEM_RD≠0 and EX_MEM_RD matches the source register.
  - Otherwise it is forwarded from MEM/WB under the same rule using MEM_WB_regwrite.
  - Otherwise the raw input is used.
  - EX/MEM has priority over MEM/WB.
  - Load results in EX/MEM (wb_sel=1) are not forwarded; software inserts one NOP after a load.
- Not defined:
  - The extra ports are absent and operands are used raw.
  - Software separates dependent instructions by 3 instructions.

## Test plan
- Reset release, all inputs 0: EX_MEM_* stay 0, pc_redirect=0, and no squash occurs.
- ADD with A=7, B=0xFFFFFFFF, alucontrol7=0: next cycle EX_MEM_ALU=6. SUB with A=5, B=7: result 0xFFFFFFFE. SRA of 0x80000000 by 4: result 0xF8000000.
- BLT (funct3=100) with A=0xFFFFFFFF, B=1, PC=0x100, IMM=0x20: pc_redirect=1 and pc_target=0x120 in the same cycle. The next two bundles, including a taken BEQ and an ADD with regwrite_en=1, register regwrite_en=0 and do not redirect. The third bundle executes normally.
- JALR with A=0x203, IMM=4, PC=0x40: pc_target=0x206, EX_MEM_ALU=0x44, EX_MEM_regwrite_en=1.
- Reset asserted while sq=2: the following bundle, a store with memwrite_en=1, registers EX_MEM_memwrite_en=1.
- EX_FWD_EN defined: ADD x5 with result 10, then ADD x6=x5+x5 with stale A=B=0: second result is 20. If the same RD is also pending in MEM/WB with WD=99, the EX/MEM value wins.

Source files
------------

// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, branch/jump resolution, PC redirect and two-bundle
// wrong-path squash. Define EX_FWD_EN to add EX/MEM and MEM/WB operand forwarding.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_EX_PC,
  input  logic [31:0] ID_EX_A,
  input  logic [31:0] ID_EX_B,
  input  logic [31:0] ID_EX_IMM,
  input  logic [4:0]  ID_EX_RD,
  input  logic [1:0]  alu_type_sel,
  input  logic [2:0]  alucontrol,
  input  logic [6:0]  alucontrol7,
  input  logic        b_imm_sel,
  input  logic        branch,
  input  logic        jump,
  input  logic        memwrite_en,
  input  logic        regwrite_en,
  input  logic        wb_sel,
`ifdef EX_FWD_EN
  input  logic [4:0]  ID_EX_RS1,
  input  logic [4:0]  ID_EX_RS2,
  input  logic        MEM_WB_regwrite,
  input  logic [4:0]  MEM_WB_RD,
  input  logic [31:0] MEM_WB_WD,
`endif
  output logic [31:0] EX_MEM_ALU,
  output logic [31:0] EX_MEM_WD,
  output logic [4:0]  EX_MEM_RD,
  output logic [2:0]  EX_MEM_F3,
  output logic        EX_MEM_memwrite_en,
  output logic        EX_MEM_regwrite_en,
  output logic        EX_MEM_wb_sel,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);

  typedef enum logic [1:0] {
    TYPE_ALU   = 2'b00,
    TYPE_ADDR  = 2'b01,
    TYPE_LUI   = 2'b10,
    TYPE_AUIPC = 2'b11
  } alu_type_e;

  logic [1:0]  sq;
  logic        squash;
  logic [31:0] op_a;
  logic [31:0] src_b;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic [31:0] ex_res;
  logic        cond;
  logic        taken;
  logic        unused_f7;

  assign unused_f7 = ^{alucontrol7[6], alucontrol7[4:0]};
  assign squash    = (sq != 2'd0);

`ifdef EX_FWD_EN
  logic ex_fwd_ok;
  logic wb_fwd_ok;

  // Loads sitting in EX/MEM have no data yet, so only ALU results are forwarded.
  assign ex_fwd_ok = EX_MEM_regwrite_en && !EX_MEM_wb_sel && (EX_MEM_RD != 5'd0);
  assign wb_fwd_ok = MEM_WB_regwrite && (MEM_WB_RD != 5'd0);

  always_comb begin
    if (ex_fwd_ok && (EX_MEM_RD == ID_EX_RS1))      op_a = EX_MEM_ALU;
    else if (wb_fwd_ok && (MEM_WB_RD == ID_EX_RS1)) op_a = MEM_WB_WD;
    else                                            op_a = ID_EX_A;

    if (ex_fwd_ok && (EX_MEM_RD == ID_EX_RS2))      src_b = EX_MEM_ALU;
    else if (wb_fwd_ok && (MEM_WB_RD == ID_EX_RS2)) src_b = MEM_WB_WD;
    else                                            src_b = ID_EX_B;
  end
`else
  assign op_a  = ID_EX_A;
  assign src_b = ID_EX_B;
`endif

  assign op_b  = b_imm_sel ? ID_EX_IMM : src_b;
  assign shamt = op_b[4:0];

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    alu_res = 32'd0;
    unique case (alucontrol)
      3'b000: alu_res = (alucontrol7[5] && !b_imm_sel) ? op_a - op_b : op_a + op_b;
      3'b001: alu_res = op_a << shamt;
      3'b010: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b011: alu_res = {31'd0, op_a < op_b};
      3'b100: alu_res = op_a ^ op_b;
      3'b101: alu_res = alucontrol7[5] ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
      3'b110: alu_res = op_a | op_b;
      3'b111: alu_res = op_a & op_b;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    ex_res = 32'd0;
    if (jump) begin
      ex_res = ID_EX_PC + 32'd4;
    end else begin
      unique case (alu_type_e'(alu_type_sel))
        TYPE_ALU:   ex_res = alu_res;
        TYPE_ADDR:  ex_res = op_a + ID_EX_IMM;
        TYPE_LUI:   ex_res = ID_EX_IMM;
        TYPE_AUIPC: ex_res = ID_EX_PC + ID_EX_IMM;
        default:    ex_res = 32'd0;
      endcase
    end
  end

  always_comb begin
    cond = 1'b0;
    unique case (alucontrol)
      3'b000:  cond = (op_a == src_b);
      3'b001:  cond = (op_a != src_b);
      3'b100:  cond = ($signed(op_a) <  $signed(src_b));
      3'b101:  cond = ($signed(op_a) >= $signed(src_b));
      3'b110:  cond = (op_a <  src_b);
      3'b111:  cond = (op_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  assign taken       = jump || (branch && cond);
  assign pc_redirect = taken && !squash;

  always_comb begin
    pc_target = 32'd0;
    if (pc_redirect) begin
      if (jump && (alu_type_sel == TYPE_ADDR)) pc_target = (op_a + ID_EX_IMM) & ~32'd1;
      else                                     pc_target = ID_EX_PC + ID_EX_IMM;
    end
  end

  // The two bundles behind a redirect are wrong-path; decode cannot flush them.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq <= 2'd0;
    end else if (pc_redirect) begin
      sq <= 2'd2;
    end else if (squash) begin
      sq <= sq - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_MEM_ALU         <= 32'd0;
      EX_MEM_WD          <= 32'd0;
      EX_MEM_RD          <= 5'd0;
      EX_MEM_F3          <= 3'd0;
      EX_MEM_memwrite_en <= 1'b0;
      EX_MEM_regwrite_en <= 1'b0;
      EX_MEM_wb_sel      <= 1'b0;
    end else begin
      EX_MEM_ALU         <= ex_res;
      EX_MEM_WD          <= src_b;
      EX_MEM_RD          <= ID_EX_RD;
      EX_MEM_F3          <= alucontrol;
      EX_MEM_memwrite_en <= memwrite_en && !squash;
      EX_MEM_regwrite_en <= regwrite_en && !squash;
      EX_MEM_wb_sel      <= wb_sel;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: constant vector table, hand-written
// redirect/squash/reset sequences and random bundles against a reference model.
module tb_execute_stage;

  typedef struct {
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rd;
    logic [1:0]  ts;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        bi, br, jp, mw, rw, wb;
    logic [4:0]  rs1, rs2;
    logic        mwb_rw;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_wd;
  } bundle_t;

  typedef struct {
    logic [31:0] alu, wd, target;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mw, rw, wb, redirect;
  } result_t;

  typedef struct {
    bundle_t     in;
    logic [31:0] exp_alu;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc, id_a, id_b, id_imm;
  logic [4:0]  id_rd;
  logic [1:0]  alu_type_sel;
  logic [2:0]  alucontrol;
  logic [6:0]  alucontrol7;
  logic        b_imm_sel, branch, jump, memwrite_en, regwrite_en, wb_sel;
  logic [4:0]  rs1, rs2, mwb_rd;
  logic        mwb_rw;
  logic [31:0] mwb_wd;
  logic [31:0] ex_alu, ex_wd, pc_target;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_f3;
  logic        ex_mw, ex_rw, ex_wb, pc_redirect;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .ID_EX_PC(id_pc), .ID_EX_A(id_a), .ID_EX_B(id_b), .ID_EX_IMM(id_imm), .ID_EX_RD(id_rd),
    .alu_type_sel(alu_type_sel), .alucontrol(alucontrol), .alucontrol7(alucontrol7),
    .b_imm_sel(b_imm_sel), .branch(branch), .jump(jump),
    .memwrite_en(memwrite_en), .regwrite_en(regwrite_en), .wb_sel(wb_sel),
`ifdef EX_FWD_EN
    .ID_EX_RS1(rs1), .ID_EX_RS2(rs2), .MEM_WB_regwrite(mwb_rw), .MEM_WB_RD(mwb_rd), .MEM_WB_WD(mwb_wd),
`endif
    .EX_MEM_ALU(ex_alu), .EX_MEM_WD(ex_wd), .EX_MEM_RD(ex_rd), .EX_MEM_F3(ex_f3),
    .EX_MEM_memwrite_en(ex_mw), .EX_MEM_regwrite_en(ex_rw), .EX_MEM_wb_sel(ex_wb),
    .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  int      n_cmp = 0;
  int      n_err = 0;
  int      bundle_idx = 0;
  int      last_redir_idx = -10;
  result_t prev;
  logic    seen_redirect;
  logic [31:0] seen_target;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic bundle_t blank();
    bundle_t b;
    b = '{pc: 0, a: 0, b: 0, imm: 0, rd: 0, ts: 0, f3: 0, f7: 0, bi: 0, br: 0, jp: 0,
          mw: 0, rw: 0, wb: 0, rs1: 0, rs2: 0, mwb_rw: 0, mwb_rd: 0, mwb_wd: 0};
    return b;
  endfunction

  function automatic bundle_t alu_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                     input logic [2:0] f3, input logic [6:0] f7, input logic bi,
                                     input logic [1:0] ts);
    bundle_t r;
    r = blank();
    r.a = a; r.b = b; r.imm = imm; r.f3 = f3; r.f7 = f7; r.bi = bi; r.ts = ts;
    r.rd = 5'd1; r.rw = 1'b1;
    return r;
  endfunction

  // Reference behaviour from the instruction-set rules; squash is decided by the
  // distance in bundles from the last accepted redirect.
  function automatic result_t model(input bundle_t b, input logic squashed, input result_t p);
    result_t r;
    logic [31:0] a, bb, opb, res;
    logic [4:0]  sh;
    logic        tk;
    a  = b.a;
    bb = b.b;
`ifdef EX_FWD_EN
    if (p.rw && !p.wb && p.rd != 0 && p.rd == b.rs1)           a = p.alu;
    else if (b.mwb_rw && b.mwb_rd != 0 && b.mwb_rd == b.rs1)   a = b.mwb_wd;
    if (p.rw && !p.wb && p.rd != 0 && p.rd == b.rs2)           bb = p.alu;
    else if (b.mwb_rw && b.mwb_rd != 0 && b.mwb_rd == b.rs2)   bb = b.mwb_wd;
`else
    if (p.rw === 1'bx) a = 'x;
`endif
    opb = b.bi ? b.imm : bb;
    sh  = opb[4:0];
    res = 0;
    case (b.f3)
      0: res = (b.f7[5] && !b.bi) ? a - opb : a + opb;
      1: res = a << sh;
      2: res = ($signed(a) < $signed(opb)) ? 1 : 0;
      3: res = (a < opb) ? 1 : 0;
      4: res = a ^ opb;
      5: res = b.f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
      6: res = a | opb;
      default: res = a & opb;
    endcase
    case (b.ts)
      1: res = a + b.imm;
      2: res = b.imm;
      3: res = b.pc + b.imm;
      default: ;
    endcase
    tk = 0;
    if (b.br)
      case (b.f3)
        0: tk = (a == bb);
        1: tk = (a != bb);
        4: tk = $signed(a) < $signed(bb);
        5: tk = $signed(a) >= $signed(bb);
        6: tk = a < bb;
        7: tk = a >= bb;
        default: tk = 0;
      endcase
    if (b.jp) tk = 1;
    r.redirect = tk && !squashed;
    r.target   = !r.redirect ? 0 : (b.jp && b.ts == 1) ? ((a + b.imm) & ~32'd1) : b.pc + b.imm;
    r.alu      = b.jp ? b.pc + 4 : res;
    r.wd       = bb;
    r.rd       = b.rd;
    r.f3       = b.f3;
    r.mw       = b.mw && !squashed;
    r.rw       = b.rw && !squashed;
    r.wb       = b.wb;
    return r;
  endfunction

  task automatic drive(input bundle_t b);
    id_pc = b.pc; id_a = b.a; id_b = b.b; id_imm = b.imm; id_rd = b.rd;
    alu_type_sel = b.ts; alucontrol = b.f3; alucontrol7 = b.f7; b_imm_sel = b.bi;
    branch = b.br; jump = b.jp; memwrite_en = b.mw; regwrite_en = b.rw; wb_sel = b.wb;
    rs1 = b.rs1; rs2 = b.rs2; mwb_rw = b.mwb_rw; mwb_rd = b.mwb_rd; mwb_wd = b.mwb_wd;
  endtask

  // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic run_bundle(input bundle_t b, input string tag);
    result_t e;
    logic    sqd;
    sqd = (bundle_idx - last_redir_idx) <= 2;
    e   = model(b, sqd, prev);
    drive(b);
    #3;
    seen_redirect = pc_redirect;
    seen_target   = pc_target;
    check({tag, " redirect"}, {31'd0, seen_redirect}, {31'd0, e.redirect});
    check({tag, " target"}, seen_target, e.target);
    @(posedge clk);
    #1;
    check({tag, " alu"}, ex_alu, e.alu);
    check({tag, " wd"}, ex_wd, e.wd);
    check({tag, " rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    check({tag, " f3"}, {29'd0, ex_f3}, {29'd0, e.f3});
    check({tag, " memwrite"}, {31'd0, ex_mw}, {31'd0, e.mw});
    check({tag, " regwrite"}, {31'd0, ex_rw}, {31'd0, e.rw});
    check({tag, " wb_sel"}, {31'd0, ex_wb}, {31'd0, e.wb});
    if (e.redirect) last_redir_idx = bundle_idx;
    bundle_idx++;
    prev = e;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " alu"}, ex_alu, 0);
    check({tag, " wd"}, ex_wd, 0);
    check({tag, " rd"}, {27'd0, ex_rd}, 0);
    check({tag, " ctl"}, {29'd0, ex_mw, ex_rw, ex_wb}, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    rst = 1'b0;
    last_redir_idx = bundle_idx - 10;
    prev = '{alu: 0, wd: 0, target: 0, rd: 0, f3: 0, mw: 0, rw: 0, wb: 0, redirect: 0};
  endtask

  vec_t    vecs[15];
  bundle_t bd;

  initial begin
    vecs[0]  = '{in: alu_op(32'd7, 32'hFFFFFFFF, 0, 3'b000, 7'h00, 0, 0), exp_alu: 32'd6};
    vecs[1]  = '{in: alu_op(32'd5, 32'd7, 0, 3'b000, 7'h20, 0, 0), exp_alu: 32'hFFFFFFFE};
    vecs[2]  = '{in: alu_op(32'h80000000, 32'd4, 0, 3'b101, 7'h20, 0, 0), exp_alu: 32'hF8000000};
    vecs[3]  = '{in: alu_op(32'h80000000, 32'd4, 0, 3'b101, 7'h00, 0, 0), exp_alu: 32'h08000000};
    vecs[4]  = '{in: alu_op(32'd1, 32'd31, 0, 3'b001, 7'h00, 0, 0), exp_alu: 32'h80000000};
    vecs[5]  = '{in: alu_op(32'hFFFFFFFF, 32'd1, 0, 3'b010, 7'h00, 0, 0), exp_alu: 32'd1};
    vecs[6]  = '{in: alu_op(32'hFFFFFFFF, 32'd1, 0, 3'b011, 7'h00, 0, 0), exp_alu: 32'd0};
    vecs[7]  = '{in: alu_op(32'hF0F0F0F0, 32'hFF00FF00, 0, 3'b100, 7'h00, 0, 0), exp_alu: 32'h0FF00FF0};
    vecs[8]  = '{in: alu_op(32'hF0F0F0F0, 32'hFF00FF00, 0, 3'b110, 7'h00, 0, 0), exp_alu: 32'hFFF0FFF0};
    vecs[9]  = '{in: alu_op(32'hF0F0F0F0, 32'hFF00FF00, 0, 3'b111, 7'h00, 0, 0), exp_alu: 32'hF000F000};
    vecs[10] = '{in: alu_op(32'd10, 32'd3, 32'hFFFFFFFF, 3'b000, 7'h20, 1, 0), exp_alu: 32'd9};
    vecs[11] = '{in: alu_op(32'd3, 32'd3, 32'h12345000, 3'b000, 7'h00, 0, 2), exp_alu: 32'h12345000};
    vecs[12] = '{in: alu_op(32'd3, 32'd3, 32'h20, 3'b000, 7'h00, 0, 3), exp_alu: 32'h1020};
    vecs[13] = '{in: alu_op(32'h100, 32'd3, 32'hFFFFFFFC, 3'b010, 7'h00, 0, 1), exp_alu: 32'hFC};
    vecs[14] = '{in: alu_op(32'd1, 32'h21, 0, 3'b001, 7'h00, 0, 0), exp_alu: 32'd2};
    vecs[12].in.pc = 32'h1000;

    rst = 1'b1;
    prev = '{alu: 0, wd: 0, target: 0, rd: 0, f3: 0, mw: 0, rw: 0, wb: 0, redirect: 0};
    drive(blank());
    #2;
    check_reset_outputs("reset");
    check("reset redirect", {31'd0, pc_redirect}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) run_bundle(blank(), $sformatf("idle%0d", i));

    for (int i = 0; i < 15; i++) begin
      run_bundle(vecs[i].in, $sformatf("vec%0d", i));
      check($sformatf("vec%0d const alu", i), ex_alu, vecs[i].exp_alu);
    end

    // BLT taken, then a taken BEQ and an ADD both squashed, third bundle normal.
    bd = blank(); bd.br = 1; bd.f3 = 3'b100; bd.a = 32'hFFFFFFFF; bd.b = 1; bd.pc = 32'h100; bd.imm = 32'h20;
    run_bundle(bd, "blt");
    check("blt redirect const", {31'd0, seen_redirect}, 1);
    check("blt target const", seen_target, 32'h120);
    bd = blank(); bd.br = 1; bd.f3 = 3'b000; bd.a = 5; bd.b = 5; bd.imm = 8; bd.rw = 1; bd.rd = 3;
    run_bundle(bd, "sq1 beq");
    check("sq1 no redirect", {31'd0, seen_redirect}, 0);
    check("sq1 regwrite const", {31'd0, ex_rw}, 0);
    run_bundle(vecs[0].in, "sq2 add");
    check("sq2 regwrite const", {31'd0, ex_rw}, 0);
    run_bundle(vecs[0].in, "post add");
    check("post regwrite const", {31'd0, ex_rw}, 1);
    check("post alu const", ex_alu, 32'd6);

    // JALR
    bd = blank(); bd.jp = 1; bd.ts = 2'b01; bd.a = 32'h203; bd.imm = 4; bd.pc = 32'h40; bd.rw = 1; bd.rd = 1;
    run_bundle(bd, "jalr");
    check("jalr target const", seen_target, 32'h206);
    check("jalr alu const", ex_alu, 32'h44);
    check("jalr regwrite const", {31'd0, ex_rw}, 1);
    run_bundle(blank(), "jalr sq1");
    run_bundle(blank(), "jalr sq2");

    // Reset while the squash window is open.
    bd = blank(); bd.jp = 1; bd.pc = 32'h80; bd.imm = 32'h10;
    run_bundle(bd, "jal");
    pulse_reset("midsq reset");
    bd = blank(); bd.mw = 1; bd.ts = 2'b01; bd.a = 32'h300; bd.imm = 8; bd.b = 32'hCAFE;
    run_bundle(bd, "store");
    check("store memwrite const", {31'd0, ex_mw}, 1);

`ifdef EX_FWD_EN
    bd = alu_op(4, 6, 0, 3'b000, 7'h00, 0, 0); bd.rd = 5;
    run_bundle(bd, "fwd x5");
    bd = alu_op(0, 0, 0, 3'b000, 7'h00, 0, 0); bd.rd = 6; bd.rs1 = 5; bd.rs2 = 5;
    bd.mwb_rw = 1; bd.mwb_rd = 5; bd.mwb_wd = 99;
    run_bundle(bd, "fwd x6");
    check("fwd exmem const", ex_alu, 32'd20);
    bd = alu_op(0, 0, 1, 3'b000, 7'h00, 1, 0); bd.rd = 7; bd.rs1 = 9;
    bd.mwb_rw = 1; bd.mwb_rd = 9; bd.mwb_wd = 99;
    run_bundle(bd, "fwd memwb");
    check("fwd memwb const", ex_alu, 32'd100);
`endif

    for (int i = 0; i < 300; i++) begin
      int kind;
      if (i % 100 == 99) pulse_reset($sformatf("rnd reset%0d", i));
      bd = blank();
      bd.pc = $urandom; bd.b = $urandom; bd.imm = $urandom;
      bd.a = ($urandom_range(3) == 0) ? bd.b : $urandom;
      if ($urandom_range(3) == 0) bd.b = $urandom_range(40);
      bd.rd = 5'($urandom_range(7)); bd.rs1 = 5'($urandom_range(7)); bd.rs2 = 5'($urandom_range(7));
      bd.ts = 2'($urandom); bd.f3 = 3'($urandom); bd.f7 = 7'($urandom); bd.bi = 1'($urandom);
      bd.mw = 1'($urandom); bd.rw = 1'($urandom); bd.wb = 1'($urandom);
      bd.mwb_rw = 1'($urandom); bd.mwb_rd = 5'($urandom_range(7)); bd.mwb_wd = $urandom;
      kind = $urandom_range(7);
      if (kind == 0) bd.br = 1;
      if (kind == 1) bd.jp = 1;
      run_bundle(bd, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
